// File: rtl/elm_layer_seq.sv
// elm_layer_seq: sequencer for one ELM hidden layer.
// Streams samples to the neuron array, waits for results, drains them.
module elm_layer_seq #(
    parameter int NUM_INPUTS  = 128,
    parameter int NUM_NEURONS = 48,
    parameter int DATA_W      = 16,
    parameter int OUT_W       = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err_timeout,
    output logic                           err_mismatch,
    output logic [$clog2(NUM_INPUTS)-1:0]  in_raddr,
    output logic                           in_ren,
    input  logic [DATA_W-1:0]              in_rdata,
    output logic                           nrn_rst,
    output logic                           nrn_in_valid,
    output logic [DATA_W-1:0]              nrn_in,
    input  logic [NUM_NEURONS-1:0]         nrn_outvalid,
    input  logic [NUM_NEURONS*OUT_W-1:0]   nrn_out,
    output logic                           out_we,
    output logic [$clog2(NUM_NEURONS)-1:0] out_waddr,
    output logic [OUT_W-1:0]               out_wdata
);

    localparam int IA_W = $clog2(NUM_INPUTS);
    localparam int OA_W = $clog2(NUM_NEURONS);
    localparam int T_W  = $clog2(TIMEOUT + 1);

    localparam logic [IA_W-1:0] IA_LAST = IA_W'(NUM_INPUTS - 1);
    localparam logic [OA_W-1:0] OA_LAST = OA_W'(NUM_NEURONS - 1);
    localparam logic [T_W-1:0]  T_LAST  = T_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_COLLECT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                         state_q, state_d;
    logic [IA_W-1:0]                raddr_q, raddr_d;
    logic [OA_W-1:0]                waddr_q, waddr_d;
    logic [T_W-1:0]                 tcnt_q, tcnt_d;
    logic [NUM_NEURONS*OUT_W-1:0]   snap_q, snap_d;
    logic                           vld_q, vld_d;
    logic                           err_to_q, err_to_d;
    logic                           err_mm_q, err_mm_d;
    logic                           rst_hold_q, rst_hold_d;
    logic                           all_v;
    logic                           any_v;

    assign all_v = &nrn_outvalid;
    assign any_v = |nrn_outvalid;

    // Next-state, counters and strobes for the layer sequence
    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        tcnt_d     = tcnt_q;
        snap_d     = snap_q;
        err_to_d   = err_to_q;
        err_mm_d   = err_mm_q;
        rst_hold_d = 1'b0;
        in_ren     = 1'b0;
        out_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_STREAM;
                    raddr_d  = '0;
                    err_to_d = 1'b0;
                    err_mm_d = 1'b0;
                end
            end
            S_STREAM: begin
                busy   = 1'b1;
                in_ren = 1'b1;
                if (any_v) begin
                    err_mm_d = 1'b1;
                    state_d  = S_ABORT;
                end else if (raddr_q == IA_LAST) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    raddr_d = raddr_q + 1'b1;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (all_v) begin
                    snap_d  = nrn_out;
                    waddr_d = '0;
                    state_d = S_COLLECT;
                end else if (any_v) begin
                    err_mm_d = 1'b1;
                    state_d  = S_ABORT;
                end else if (tcnt_q == T_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = S_ABORT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                busy   = 1'b1;
                out_we = 1'b1;
                if (waddr_q == OA_LAST) begin
                    state_d = S_DONE;
                end else begin
                    waddr_d = waddr_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // a beat fetched in the cycle that aborts is dropped
        vld_d = in_ren & (state_d != S_ABORT);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            waddr_q    <= '0;
            tcnt_q     <= '0;
            snap_q     <= '0;
            vld_q      <= 1'b0;
            err_to_q   <= 1'b0;
            err_mm_q   <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            tcnt_q     <= tcnt_d;
            snap_q     <= snap_d;
            vld_q      <= vld_d;
            err_to_q   <= err_to_d;
            err_mm_q   <= err_mm_d;
            rst_hold_q <= rst_hold_d;
        end
    end

    assign in_raddr     = raddr_q;
    assign nrn_in_valid = vld_q;
    assign nrn_in       = vld_q ? in_rdata : '0;
    assign nrn_rst      = rst_hold_q | (state_q == S_ABORT);
    assign err_timeout  = err_to_q;
    assign err_mismatch = err_mm_q;
    assign out_waddr    = out_we ? waddr_q : '0;
    assign out_wdata    = out_we ? snap_q[int'(waddr_q) * OUT_W +: OUT_W] : '0;

endmodule

// File: tb/tb_elm_layer_seq.sv
// tb_elm_layer_seq: randomized and directed checks of elm_layer_seq.
// Holds an input buffer, a behavioural neuron array and a monitor.
module tb_elm_layer_seq;

    localparam int NI = 8;
    localparam int NN = 4;
    localparam int DW = 16;
    localparam int OW = 16;
    localparam int TO = 16;
    localparam int IA = $clog2(NI);
    localparam int OA = $clog2(NN);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_mismatch;
    logic [IA-1:0]    in_raddr;
    logic             in_ren;
    logic [DW-1:0]    in_rdata = '0;
    logic             nrn_rst;
    logic             nrn_in_valid;
    logic [DW-1:0]    nrn_in;
    logic [NN-1:0]    nrn_outvalid = '0;
    logic [NN*OW-1:0] nrn_out = '0;
    logic             out_we;
    logic [OA-1:0]    out_waddr;
    logic [OW-1:0]    out_wdata;

    elm_layer_seq #(
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .DATA_W     (DW),
        .OUT_W      (OW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_mismatch(err_mismatch),
        .in_raddr    (in_raddr),
        .in_ren      (in_ren),
        .in_rdata    (in_rdata),
        .nrn_rst     (nrn_rst),
        .nrn_in_valid(nrn_in_valid),
        .nrn_in      (nrn_in),
        .nrn_outvalid(nrn_outvalid),
        .nrn_out     (nrn_out),
        .out_we      (out_we),
        .out_waddr   (out_waddr),
        .out_wdata   (out_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // input buffer: samples of the current inference
    logic [DW-1:0] mem [NI];

    always @(posedge clk) begin
        if (in_ren) in_rdata <= mem[in_raddr];
    end

    // neuron array behaviour: 0=all fire, 1=only neuron 2, 2=silent
    int            nmode  = 0;
    int            ndelay = 5;
    logic [OW-1:0] nbase  = '0;
    int            nb     = 0;
    int            cd     = -1;

    function automatic logic [OW-1:0] exp_out(input int k);
        return nbase + OW'(k);
    endfunction

    always @(negedge clk) begin
        if (rst || nrn_rst) begin
            nb = 0;
            cd = -1;
            nrn_outvalid = '0;
        end else begin
            nrn_outvalid = '0;
            for (int k = 0; k < NN; k++) nrn_out[k*OW +: OW] = OW'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cd = -1;
                    for (int k = 0; k < NN; k++) nrn_out[k*OW +: OW] = exp_out(k);
                    if (nmode == 0) nrn_outvalid = '1;
                    else if (nmode == 1) nrn_outvalid[2] = 1'b1;
                end
            end
            if (nrn_in_valid) begin
                nb++;
                if (nb == NI) begin
                    nb = 0;
                    cd = ndelay;
                end
            end
        end
    end

    // monitor: compares every beat and write against the model
    int            run_id  = 0;
    int            seen_id = 0;
    int            cyc     = 0;
    int            bcnt, wcnt, dcnt, rcnt;
    int            first_b, last_b, abort_c;
    bit            ended;
    logic [DW-1:0] bq [$];
    logic [OW-1:0] wdq [$];

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            bcnt = 0; wcnt = 0; dcnt = 0; rcnt = 0;
            first_b = 0; last_b = 0; abort_c = 0;
            ended = 1'b0;
            bq.delete();
            wdq.delete();
        end
        cyc++;
        if (!rst) begin
            if (nrn_in_valid) begin
                chk("beat_in_range", 32'(bcnt < NI), 1);
                if (bcnt < NI) chk("beat_data", nrn_in, mem[bcnt]);
                if (bcnt == 0) first_b = cyc;
                last_b = cyc;
                bcnt++;
                bq.push_back(nrn_in);
            end
            if (out_we) begin
                chk("wr_in_range", 32'(wcnt < NN), 1);
                if (wcnt < NN) begin
                    chk("wr_addr", out_waddr, wcnt);
                    chk("wr_data", out_wdata, exp_out(wcnt));
                end
                wcnt++;
                wdq.push_back(out_wdata);
            end
            if (done) begin
                dcnt++;
                ended = 1'b1;
            end
            if (nrn_rst) begin
                if (rcnt == 0) abort_c = cyc;
                rcnt++;
                ended = 1'b1;
            end
        end
    end

    task automatic load_ramp();
        for (int i = 0; i < NI; i++) mem[i] = DW'(i + 1);
    endtask

    task automatic load_rand();
        for (int i = 0; i < NI; i++) mem[i] = DW'($urandom);
    endtask

    task automatic run_inf(input int hold);
        int n;
        run_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("start_accepted", busy, 1);
        repeat (hold - 1) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ended && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("run_ended", ended, 1);
    endtask

    task automatic check_run(input int ew, input int ed,
                             input int eto, input int emm);
        chk("beat_count", bcnt, NI);
        chk("beat_contig", last_b - first_b, NI - 1);
        chk("write_count", wcnt, ew);
        chk("done_count", dcnt, ed);
        chk("nrn_rst_pulses", rcnt, 1 - ed);
        chk("err_timeout", err_timeout, eto);
        chk("err_mismatch", err_mismatch, emm);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load_ramp();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ren", in_ren, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_valid", nrn_in_valid, 0);
        chk("rst_errs", {err_timeout, err_mismatch}, 0);
        chk("rst_nrn_rst", nrn_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("nrn_rst_hold", nrn_rst, 1);
        @(negedge clk);
        chk("nrn_rst_release", nrn_rst, 0);

        // T1 nominal
        load_ramp();
        nbase = 16'h00A0; nmode = 0; ndelay = 5;
        run_inf(1);
        check_run(NN, 1, 0, 0);
        chk("t1_beat0", bq[0], 16'h0001);
        chk("t1_beat7", bq[7], 16'h0008);
        chk("t1_wr0", wdq[0], 16'h00A0);
        chk("t1_wr3", wdq[3], 16'h00A3);
        repeat (2) @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // T2 timeout
        load_rand();
        nmode = 2;
        run_inf(1);
        check_run(0, 0, 1, 0);
        chk("t2_abort_time", abort_c - last_b, TO + 1);

        // T3 mismatch, then a clean run clears the flag
        load_rand();
        nmode = 1;
        run_inf(1);
        check_run(0, 0, 0, 1);
        load_ramp();
        nmode = 0; nbase = 16'h00A0;
        run_inf(1);
        check_run(NN, 1, 0, 0);

        // T4 start held high through the run
        load_rand();
        nbase = OW'($urandom); ndelay = 10;
        run_inf(20);
        check_run(NN, 1, 0, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("t4_no_restart", busy, 0);
        chk("t4_beats", bcnt, NI);
        chk("t4_dones", dcnt, 1);

        // T5 async reset at beat 3
        load_rand();
        ndelay = 5;
        run_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && bcnt < 3; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_reach_beat3", bcnt, 3);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_in_ren", in_ren, 0);
        chk("t5_raddr", in_raddr, 0);
        chk("t5_valid", nrn_in_valid, 0);
        chk("t5_nrn_in", nrn_in, 0);
        chk("t5_out_we", out_we, 0);
        chk("t5_nrn_rst", nrn_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_nrn_rst_hold", nrn_rst, 1);
        @(negedge clk);
        chk("t5_nrn_rst_low", nrn_rst, 0);
        load_ramp();
        nbase = 16'h00A0;
        run_inf(1);
        check_run(NN, 1, 0, 0);

        // T6 back-to-back randomized runs
        for (int r = 0; r < 3; r++) begin
            load_rand();
            nbase  = OW'($urandom);
            ndelay = $urandom_range(1, 12);
            run_inf(1);
            check_run(NN, 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
